alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer that implements unsigned MUL (low word), DIVU and REMU with the existing shared ALU.
- The ALU is reused for one operation per cycle through an external mux, which is selected by this block's busy output. The block adds no multiplier or divider hardware of its own.
- Sits beside the execute stage. The core issues a request over a valid/ready handshake and stalls until the response handshake completes.

---
 rtl/alu_muldiv_seq.sv | 205 ++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle unsigned MUL (low word) / DIVU / REMU sequencer
// that borrows the shared execute-stage ALU through an external mux (busy).
// Shift-and-add multiply, restoring division (compare cycle + subtract cycle).
// Optional macro MULDIV_EARLY_OUT_EN: trivial operands (zero multiplicand or
// multiplier, zero divisor) complete in one cycle without touching the ALU.
module alu_muldiv_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [DATA_WIDTH-1:0]    req_a,
  input  logic [DATA_WIDTH-1:0]    req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic                     busy,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  output logic [DATA_WIDTH-1:0]    alu_a,
  output logic [DATA_WIDTH-1:0]    alu_b,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  localparam logic [OPCODE_LENGTH-1:0] OP_NONE = '0;
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_GEU  = OPCODE_LENGTH'(4'b1010);

  typedef enum logic [2:0] {IDLE, MUL, DIV_CMP, DIV_SUB, DONE} state_t;

  state_t        state_reg;
  logic [1:0]    op_reg;
  logic [N-1:0]  mcand_reg;    // multiplicand already aligned for the next ALU cycle
  logic [N-1:0]  mplier_reg;   // multiplier bits not yet presented to the ALU
  logic [N-1:0]  quo_reg;      // dividend shifting out the top, quotient shifting in
  logic [N-1:0]  rem_reg;
  logic [N-1:0]  divisor_reg;
  logic [N-1:0]  rs_reg;       // shifted partial remainder held for the subtract cycle
  logic          qbit_reg;     // quotient bit decided in the compare cycle
  logic [CW-1:0] counter_reg;

  logic [N-1:0]  rs_next;
  logic          qbit_next;
  logic [N-1:0]  rem_next;

  // Restoring-division datapath helpers; the ALU does the compare and subtract.
  always_comb begin
    rs_next   = {rem_reg[N-2:0], quo_reg[N-1]};
    // A set rem MSB means rs overflowed N bits, so rs >= divisor regardless of the ALU compare.
    qbit_next = rem_reg[N-1] | alu_result[0];
    // Modulo-2^N wrap of the ALU subtract is exact in the overflow case.
    rem_next  = qbit_reg ? alu_result : rs_reg;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic         early_hit;
  logic [N-1:0] early_data;

  // Operand patterns whose result is known without iterating.
  always_comb begin
    early_hit  = 1'b0;
    early_data = '0;
    case (req_op)
      2'b00: early_hit = (req_a == '0) || (req_b == '0);
      2'b01: begin early_hit = (req_b == '0); early_data = '1;    end
      2'b10: begin early_hit = (req_b == '0); early_data = req_a; end
      default: ;
    endcase
  end
`endif

  // Sequencer: state, iteration registers and registered ALU/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      op_reg      <= 2'b00;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      rs_reg      <= '0;
      qbit_reg    <= 1'b0;
      counter_reg <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      busy        <= 1'b0;
      alu_op      <= OP_NONE;
      alu_a       <= '0;
      alu_b       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_reg      <= req_op;
            mcand_reg   <= req_a << 1;
            mplier_reg  <= req_b >> 1;
            quo_reg     <= req_a;
            divisor_reg <= req_b;
            rem_reg     <= '0;
            counter_reg <= CW'(N);
            req_ready   <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            if (early_hit) begin
              state_reg  <= DONE;
              resp_valid <= 1'b1;
              resp_data  <= early_data;
            end else
`endif
            begin
              case (req_op)
                2'b00: begin
                  // Accumulator starts at zero; first partial product uses multiplier bit 0.
                  state_reg <= MUL;
                  busy      <= 1'b1;
                  alu_op    <= OP_ADD;
                  alu_a     <= '0;
                  alu_b     <= req_b[0] ? req_a : '0;
                end
                2'b01, 2'b10: begin
                  state_reg <= DIV_CMP;
                  busy      <= 1'b1;
                  alu_op    <= OP_GEU;
                  alu_a     <= {{(N-1){1'b0}}, req_a[N-1]};
                  alu_b     <= req_b;
                end
                default: begin
                  state_reg  <= DONE;
                  resp_valid <= 1'b1;
                  resp_data  <= '0;
                end
              endcase
            end
          end
        end

        MUL: begin
          mcand_reg   <= mcand_reg << 1;
          mplier_reg  <= mplier_reg >> 1;
          counter_reg <= counter_reg - CW'(1);
          if (counter_reg == CW'(1)) begin
            state_reg  <= DONE;
            resp_valid <= 1'b1;
            resp_data  <= alu_result;
            busy       <= 1'b0;
            alu_op     <= OP_NONE;
            alu_a      <= '0;
            alu_b      <= '0;
          end else begin
            // alu_a doubles as the running accumulator.
            alu_a <= alu_result;
            alu_b <= mplier_reg[0] ? mcand_reg : '0;
          end
        end

        DIV_CMP: begin
          rs_reg    <= rs_next;
          qbit_reg  <= qbit_next;
          quo_reg   <= {quo_reg[N-2:0], qbit_next};
          state_reg <= DIV_SUB;
          alu_op    <= OP_SUB;
          alu_a     <= rs_next;
          alu_b     <= divisor_reg;
        end

        DIV_SUB: begin
          rem_reg     <= rem_next;
          counter_reg <= counter_reg - CW'(1);
          if (counter_reg == CW'(1)) begin
            state_reg  <= DONE;
            resp_valid <= 1'b1;
            resp_data  <= (op_reg == 2'b10) ? rem_next : quo_reg;
            busy       <= 1'b0;
            alu_op     <= OP_NONE;
            alu_a      <= '0;
            alu_b      <= '0;
          end else begin
            state_reg <= DIV_CMP;
            alu_op    <= OP_GEU;
            alu_a     <= {rem_next[N-2:0], quo_reg[N-1]};
            alu_b     <= divisor_reg;
          end
        end

        DONE: begin
          if (resp_ready) begin
            state_reg  <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed-vector bench for alu_muldiv_seq with a behavioural model of the shared ALU.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;

  int n_vec  = 0;
  int n_miss = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_DIV0 = 1;
`else
  localparam int LAT_DIV0 = 65;
`endif

  alu_muldiv_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  // Shared ALU: ADD, SUB and unsigned greater-or-equal.
  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b1010: alu_result = {31'h0, (alu_a >= alu_b)};
      default: alu_result = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Issue one request with resp_ready high; check latency, result, busy span and ALU op sequence.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int cyc;
    int busy_cnt;
    int op_ok;
    logic [3:0] eop;
    @(negedge clk);
    check({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_op     = op;
    req_a      = a;
    req_b      = b;
    resp_ready = 1'b1;
    @(posedge clk);
    cyc = 0; busy_cnt = 0; op_ok = 0;
    do begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      if (busy) begin
        busy_cnt++;
        eop = (op == 2'b00) ? 4'b0010 : ((cyc % 2 == 1) ? 4'b1010 : 4'b0110);
        if (alu_op == eop) op_ok++;
      end
    end while (!resp_valid && cyc < 200);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_data"}, resp_data, exp);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check({tag, "_aluop_seq"}, 32'(op_ok), 32'(exp_lat - 1));
    @(negedge clk);
    check({tag, "_ready_after"}, {31'h0, req_ready}, 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  {31'h0, req_ready},  32'h1);
    check({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
    check({tag, "_resp_data"},  resp_data,           32'h0);
    check({tag, "_busy"},       {31'h0, busy},       32'h0);
    check({tag, "_alu_op"},     {28'h0, alu_op},     32'h0);
    check({tag, "_alu_a"},      alu_a,               32'h0);
    check({tag, "_alu_b"},      alu_b,               32'h0);
  endtask

  initial begin
    int cyc;
    int stable;
    logic [31:0] hold;

    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = 32'h0; req_b = 32'h0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;

    run_op("mul_7x6",    2'b00, 32'd7,        32'd6,        32'd42,       33);
    run_op("mul_ffxff",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run_op("divu_100_7", 2'b01, 32'd100,      32'd7,        32'd14,       65);
    run_op("remu_100_7", 2'b10, 32'd100,      32'd7,        32'd2,        65);
    run_op("divu_8m_3",  2'b01, 32'h80000000, 32'd3,        32'h2AAAAAAA, 65);
    run_op("remu_8m_3",  2'b10, 32'h80000000, 32'd3,        32'd2,        65);
    run_op("divu_ovf",   2'b01, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 65);
    run_op("remu_ovf",   2'b10, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 65);
    run_op("divu_5_0",   2'b01, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_DIV0);
    run_op("remu_5_0",   2'b10, 32'd5,        32'd0,        32'd5,        LAT_DIV0);
    run_op("reserved",   2'b11, 32'd9,        32'd9,        32'd0,        1);

    // Backpressure: hold resp_ready low 10 cycles while a competing request is offered.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd100; req_b = 32'd7; resp_ready = 1'b0;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
    end while (!resp_valid && cyc < 200);
    check("bp_latency", 32'(cyc), 32'd65);
    hold = resp_data;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_op = 2'b00; req_a = 32'd2; req_b = 32'd2;
      @(negedge clk);
      if (resp_valid && resp_data == hold && !req_ready && !busy) stable++;
    end
    check("bp_stable_cycles", 32'(stable), 32'd10);
    check("bp_data", resp_data, 32'd14);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", {31'h0, req_ready}, 32'h1);
    check("bp_idle_valid", {31'h0, resp_valid}, 32'h0);

    // Reset in cycle 20 of a DIVU aborts it.
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd100; req_b = 32'd7;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
    end while (cyc < 20);
    check("abort_busy_before", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    reset = 1'b0;
    run_op("mul_3x3", 2'b00, 32'd3, 32'd3, 32'd9, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
